// File: rtl/dma_pkg.sv
// Shared definitions for the DMA engine: default sizes, FSM state encoding and
// a width helper for the word counters.
package dma_pkg;

  localparam int DMA_WORD_SIZE = 16;
  localparam int DMA_BURST     = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_XFER    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DONE    = 3'd4
  } dma_state_t;

  // Bits needed to hold the values 0..max_count.
  function automatic int count_width(input int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/dma_word_counter.sv
// Loadable down-counter with zero and last-word flags. It is used both for the
// words left in the transfer and for the words left in the current bus tenure.
module dma_word_counter
  import dma_pkg::*;
#(
  parameter int WIDTH = DMA_WORD_SIZE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dec,
  output logic             zero,
  output logic             last
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - WIDTH'(1);
    end
  end

  assign zero = (count_reg == '0);
  assign last = (count_reg == WIDTH'(1));

endmodule

// File: rtl/dma_controller.sv
// Bus-master DMA engine: copies a block of device words into data memory in
// bursts, requesting the memory port from the CPU with BR/BG and owning it
// (writeToData) only while words are actually being moved.
module dma_controller
  import dma_pkg::*;
#(
  parameter int WORD_SIZE = DMA_WORD_SIZE,
  parameter int BURST     = DMA_BURST
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  input  logic [WORD_SIZE-1:0] cmd_addr,
  input  logic [WORD_SIZE-1:0] cmd_length,
  input  logic                 BG,
  output logic                 BR,
  output logic                 writeToData,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_data,
  output logic                 mem_write,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] dev_data,
  input  logic                 dev_valid,
  output logic                 dev_ready,
  output logic                 dma_end
);

  localparam int BURST_W = count_width(BURST);

  dma_state_t           state_reg, state_next;
  logic [WORD_SIZE-1:0] addr_reg;
  logic [WORD_SIZE-1:0] mem_addr_reg;
  logic [WORD_SIZE-1:0] mem_data_reg;
  logic                 mem_write_reg;
  logic                 dma_end_reg;

  logic accept, issue;
  logic rem_load, rem_dec, rem_zero, rem_last;
  logic burst_load, burst_dec, burst_zero, burst_last;

  dma_word_counter #(.WIDTH(WORD_SIZE)) u_remaining (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (rem_load),
    .load_value (cmd_length),
    .dec        (rem_dec),
    .zero       (rem_zero),
    .last       (rem_last)
  );

  dma_word_counter #(.WIDTH(BURST_W)) u_burst (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (burst_load),
    .load_value (BURST_W'(BURST)),
    .dec        (burst_dec),
    .zero       (burst_zero),
    .last       (burst_last)
  );

  // A word is retired on the cycle memory acknowledges the held write.
  assign accept = (state_reg == ST_XFER) && mem_write_reg && mem_ack;

  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    rem_load   = 1'b0;
    rem_dec    = 1'b0;
    burst_load = 1'b0;
    burst_dec  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          rem_load   = 1'b1;
          state_next = (cmd_length == '0) ? ST_DONE : ST_REQ;
        end
      end
      ST_REQ: begin
        // First write is launched on the grant edge itself to save a cycle.
        if (BG && !rem_zero) begin
          state_next = ST_XFER;
          burst_load = 1'b1;
          issue      = dev_valid;
        end
      end
      ST_XFER: begin
        if (accept) begin
          rem_dec   = 1'b1;
          burst_dec = 1'b1;
          if (rem_last) begin
            state_next = ST_DONE;
          end else if (burst_last || burst_zero) begin
            state_next = ST_RELEASE;
          end else if (!BG) begin
            state_next = ST_REQ;
          end
        end else if (!mem_write_reg) begin
          if (!BG) begin
            state_next = ST_REQ;
          end else begin
            issue = dev_valid;
          end
        end
      end
      ST_RELEASE: state_next = ST_REQ;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      mem_addr_reg  <= '0;
      mem_data_reg  <= '0;
      mem_write_reg <= 1'b0;
      dma_end_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      dma_end_reg <= (state_reg == ST_DONE);
      if ((state_reg == ST_IDLE) && cmd_valid) begin
        addr_reg <= cmd_addr;
      end else if (accept) begin
        addr_reg <= addr_reg + WORD_SIZE'(1);
      end
      if (issue) begin
        mem_write_reg <= 1'b1;
        mem_addr_reg  <= addr_reg;
        mem_data_reg  <= dev_data;
      end else if (accept) begin
        mem_write_reg <= 1'b0;
      end
    end
  end

  assign BR          = (state_reg == ST_REQ) || (state_reg == ST_XFER);
  assign writeToData = (state_reg == ST_XFER);
  assign mem_write   = mem_write_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_data    = mem_data_reg;
  assign dev_ready   = accept;
  assign dma_end     = dma_end_reg;

endmodule
